// File: rtl/texture_shade_stage.sv
// Texture-and-shade stage: U/V interpolation, texel fetch, CLUT fetch and colour blend.
// Optional feature macro TEXSHADE_CHROMA_KEY_EN drops pixels whose palette index equals i_key_index.
module texture_shade_stage #(
  parameter int FRAC_W     = 8,
  parameter int CH_W       = 8,
  parameter int TEX_W_LOG2 = 8,
  parameter int TEX_H_LOG2 = 8,
  parameter int IDX_W      = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic signed [15:0]                   i_x,
  input  logic signed [15:0]                   i_y,
  input  logic signed [16+FRAC_W-1:0]          i_w1,
  input  logic signed [16+FRAC_W-1:0]          i_w2,
  input  logic signed [16+FRAC_W-1:0]          i_w3,
  input  logic signed [16+FRAC_W-1:0]          i_u1,
  input  logic signed [16+FRAC_W-1:0]          i_u2,
  input  logic signed [16+FRAC_W-1:0]          i_u3,
  input  logic signed [16+FRAC_W-1:0]          i_v1,
  input  logic signed [16+FRAC_W-1:0]          i_v2,
  input  logic signed [16+FRAC_W-1:0]          i_v3,
  input  logic [CH_W-1:0]                      i_r,
  input  logic [CH_W-1:0]                      i_g,
  input  logic [CH_W-1:0]                      i_b,
  input  logic                                 i_clamp,
  input  logic [1:0]                           i_blend,
  input  logic [IDX_W-1:0]                     i_key_index,
  output logic                                 o_tex_rd,
  output logic [TEX_W_LOG2+TEX_H_LOG2-1:0]     o_tex_addr,
  input  logic [IDX_W-1:0]                     i_tex_data,
  output logic                                 o_clut_rd,
  output logic [IDX_W-1:0]                     o_clut_addr,
  input  logic [CH_W-1:0]                      i_clut_r,
  input  logic [CH_W-1:0]                      i_clut_g,
  input  logic [CH_W-1:0]                      i_clut_b,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic signed [15:0]                   o_x,
  output logic signed [15:0]                   o_y,
  output logic [CH_W-1:0]                      o_r,
  output logic [CH_W-1:0]                      o_g,
  output logic [CH_W-1:0]                      o_b
);
  localparam int FX_W = 16 + FRAC_W;
  localparam int PW   = 2 * FX_W + 2;
  localparam logic signed [FX_W-1:0] U_MAX = FX_W'((1 << TEX_W_LOG2) - 1);
  localparam logic signed [FX_W-1:0] V_MAX = FX_W'((1 << TEX_H_LOG2) - 1);

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [CH_W-1:0]    r;
    logic [CH_W-1:0]    g;
    logic [CH_W-1:0]    b;
    logic [1:0]         blend;
`ifdef TEXSHADE_CHROMA_KEY_EN
    logic [IDX_W-1:0]   key;
`endif
  } side_t;

  // Weighted coordinate sum reduced straight to its integer texel part (floor).
  function automatic logic signed [FX_W-1:0] interp(
    input logic signed [FX_W-1:0] w1, w2, w3, a1, a2, a3);
    logic signed [PW-1:0] sum;
    sum = PW'(w2) * PW'(a1) + PW'(w3) * PW'(a2) + PW'(w1) * PW'(a3);
    return FX_W'(sum >>> (2 * FRAC_W));
  endfunction

  function automatic logic [TEX_W_LOG2-1:0] fold_u(input logic signed [FX_W-1:0] ui,
                                                   input logic clamp);
    if (clamp && ui < 0) return '0;
    if (clamp && ui > U_MAX) return '1;
    return ui[TEX_W_LOG2-1:0];
  endfunction

  function automatic logic [TEX_H_LOG2-1:0] fold_v(input logic signed [FX_W-1:0] vi,
                                                   input logic clamp);
    if (clamp && vi < 0) return '0;
    if (clamp && vi > V_MAX) return '1;
    return vi[TEX_H_LOG2-1:0];
  endfunction

  function automatic logic [CH_W-1:0] blend(input logic [1:0] mode,
                                            input logic [CH_W-1:0] c, t);
    logic [CH_W:0]     sum;
    logic [2*CH_W-1:0] prod;
    sum  = {1'b0, c} + {1'b0, t};
    prod = (2*CH_W)'(c) * ((2*CH_W)'(t) + (2*CH_W)'(1));
    case (mode)
      2'd0:    return sum[CH_W] ? '1 : sum[CH_W-1:0];
      2'd1:    return CH_W'(prod >> CH_W);
      2'd2:    return t;
      default: return c;
    endcase
  endfunction

  logic                   adv;
  logic                   vld_p0, vld_p1, vld_p2, vld_p3;
  logic signed [FX_W-1:0] ui_p0, vi_p0;
  logic                   clamp_p0;
  side_t                  sb_in, sb_p0, sb_p1, sb_p2, sb_p3;
  logic                   drop_p3;

  assign adv         = !o_valid || i_ready;
  assign o_ready     = adv;
  assign o_tex_rd    = adv && vld_p1;
  assign o_clut_rd   = adv && vld_p2;
  assign o_clut_addr = vld_p2 ? i_tex_data : '0;

  always_comb begin
    sb_in       = '0;
    sb_in.x     = i_x;
    sb_in.y     = i_y;
    sb_in.r     = i_r;
    sb_in.g     = i_g;
    sb_in.b     = i_b;
    sb_in.blend = i_blend;
`ifdef TEXSHADE_CHROMA_KEY_EN
    sb_in.key   = i_key_index;
`endif
  end

`ifdef TEXSHADE_CHROMA_KEY_EN
  logic [IDX_W-1:0] idx_p3;
  assign drop_p3 = (idx_p3 == sb_p3.key);
`else
  logic unused_key;
  assign drop_p3    = 1'b0;
  assign unused_key = ^i_key_index;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      o_valid <= 1'b0;
    end else if (adv) begin
      vld_p0  <= i_valid;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      o_valid <= vld_p3 && !drop_p3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (adv) begin
      // S0: accept, interpolate integer texel coordinates
      ui_p0    <= interp(i_w1, i_w2, i_w3, i_u1, i_u2, i_u3);
      vi_p0    <= interp(i_w1, i_w2, i_w3, i_v1, i_v2, i_v3);
      clamp_p0 <= i_clamp;
      sb_p0    <= sb_in;
      // S1: texel address issued
      sb_p1    <= sb_p0;
      // S2: palette index returned, CLUT read issued
      sb_p2    <= sb_p1;
      // S3: CLUT colour returned, blend on the way to the output register
      sb_p3    <= sb_p2;
`ifdef TEXSHADE_CHROMA_KEY_EN
      idx_p3   <= i_tex_data;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tex_addr <= '0;
      o_x        <= '0;
      o_y        <= '0;
      o_r        <= '0;
      o_g        <= '0;
      o_b        <= '0;
    end else if (adv) begin
      if (vld_p0) o_tex_addr <= {fold_v(vi_p0, clamp_p0), fold_u(ui_p0, clamp_p0)};
      if (vld_p3 && !drop_p3) begin
        o_x <= sb_p3.x;
        o_y <= sb_p3.y;
        o_r <= blend(sb_p3.blend, sb_p3.r, i_clut_r);
        o_g <= blend(sb_p3.blend, sb_p3.g, i_clut_g);
        o_b <= blend(sb_p3.blend, sb_p3.b, i_clut_b);
      end
    end
  end
endmodule

// File: tb/tb_texture_shade_stage.sv
// Bench for texture_shade_stage: RAM models, a spec-level pixel model with scoreboard, directed vectors.
`timescale 1ns/1ps
module tb_texture_shade_stage;
  localparam int FRAC = 8;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_valid, o_ready, i_ready, o_valid;
  logic signed [15:0] i_x, i_y, o_x, o_y;
  logic signed [23:0] i_w1, i_w2, i_w3, i_u1, i_u2, i_u3, i_v1, i_v2, i_v3;
  logic [7:0] i_r, i_g, i_b, o_r, o_g, o_b;
  logic i_clamp;
  logic [1:0] i_blend;
  logic [7:0] i_key_index;
  logic o_tex_rd, o_clut_rd;
  logic [15:0] o_tex_addr;
  logic [7:0] i_tex_data, o_clut_addr, i_clut_r, i_clut_g, i_clut_b;

  always #5 i_clk = ~i_clk;

  texture_shade_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y(i_y), .i_w1(i_w1), .i_w2(i_w2), .i_w3(i_w3),
    .i_u1(i_u1), .i_u2(i_u2), .i_u3(i_u3), .i_v1(i_v1), .i_v2(i_v2), .i_v3(i_v3),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_clamp(i_clamp), .i_blend(i_blend),
    .i_key_index(i_key_index), .o_tex_rd(o_tex_rd), .o_tex_addr(o_tex_addr),
    .i_tex_data(i_tex_data), .o_clut_rd(o_clut_rd), .o_clut_addr(o_clut_addr),
    .i_clut_r(i_clut_r), .i_clut_g(i_clut_g), .i_clut_b(i_clut_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_y(o_y),
    .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  // Synchronous RAMs that hold their data while not read
  logic [7:0] tex_mem [0:65535];
  logic [7:0] clut_r [0:255];
  logic [7:0] clut_g [0:255];
  logic [7:0] clut_b [0:255];
  always @(posedge i_clk) begin
    if (o_tex_rd) i_tex_data <= tex_mem[o_tex_addr];
    if (o_clut_rd) begin
      i_clut_r <= clut_r[o_clut_addr];
      i_clut_g <= clut_g[o_clut_addr];
      i_clut_b <= clut_b[o_clut_addr];
    end
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, out_cnt = 0;
  bit lat_mode = 0, rdy_mode = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Spec-level model
  function automatic int uv_int(int w1, int w2, int w3, int a1, int a2, int a3);
    longint s;
    s = longint'(w2) * a1 + longint'(w3) * a2 + longint'(w1) * a3;
    return int'(s >>> (2 * FRAC));
  endfunction

  function automatic int fold(int v, bit cl);
    if (cl) return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    return v & 255;
  endfunction

  function automatic int shade(int mode, int c, int t);
    case (mode)
      0: return (c + t > 255) ? 255 : c + t;
      1: return (c * (t + 1)) / 256;
      2: return t;
      default: return c;
    endcase
  endfunction

  typedef struct { int x, y, r, g, b, acc; bit lat; } exp_t;
  exp_t exp_q[$];
  int   addr_q[$];

  typedef struct {
    int w1, w2, w3, u1, u2, u3, v1, v2, v3, x, y, r, g, b, mode, key;
    bit clamp;
  } pix_t;

  function automatic pix_t mk(int u, int v, int x, int y, int r, int g, int b,
                              bit cl, int mode, int key);
    pix_t p;
    p.w1 = 256; p.w2 = 0; p.w3 = 0;
    p.u1 = 777; p.u2 = -555; p.u3 = u * 256;
    p.v1 = -999; p.v2 = 333; p.v3 = v * 256;
    p.x = x; p.y = y; p.r = r; p.g = g; p.b = b;
    p.clamp = cl; p.mode = mode; p.key = key;
    return p;
  endfunction

  // Compare process: reads, stall holding, output scoreboard, model push on accept
  bit held = 0;
  logic signed [15:0] hx;
  logic [7:0] hr, hg, hb;
  initial begin
    exp_t e;
    int ui, vi, a, idx;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        held = 0;
      end else begin
        if (o_tex_rd) begin
          check("tex_rd_while_stalled", (o_valid && !i_ready) ? 0 : 1, 1);
          if (addr_q.size() == 0) check("tex_rd_spurious", 1, 0);
          else check("tex_addr", o_tex_addr, addr_q.pop_front());
        end
        if (o_clut_rd) check("clut_rd_while_stalled", (o_valid && !i_ready) ? 0 : 1, 1);
        if (held) begin
          check("hold_valid", o_valid, 1);
          check("hold_x", o_x, hx);
          check("hold_r", o_r, hr);
          check("hold_g", o_g, hg);
          check("hold_b", o_b, hb);
        end
        held = o_valid && !i_ready;
        hx = o_x; hr = o_r; hg = o_g; hb = o_b;
        if (o_valid && i_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) check("spurious_out", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_x", o_x, e.x);
            check("out_y", o_y, e.y);
            check("out_r", o_r, e.r);
            check("out_g", o_g, e.g);
            check("out_b", o_b, e.b);
            if (e.lat) check("latency", cyc - e.acc, 4);
          end
        end
        if (i_valid && o_ready) begin
          ui = uv_int(int'(i_w1), int'(i_w2), int'(i_w3), int'(i_u1), int'(i_u2), int'(i_u3));
          vi = uv_int(int'(i_w1), int'(i_w2), int'(i_w3), int'(i_v1), int'(i_v2), int'(i_v3));
          a = fold(vi, i_clamp) * 256 + fold(ui, i_clamp);
          addr_q.push_back(a);
          idx = int'(tex_mem[a]);
`ifdef TEXSHADE_CHROMA_KEY_EN
          if (idx != int'(i_key_index)) begin
`else
          begin
`endif
            e.x = int'(i_x); e.y = int'(i_y);
            e.r = shade(int'(i_blend), int'(i_r), int'(clut_r[idx]));
            e.g = shade(int'(i_blend), int'(i_g), int'(clut_g[idx]));
            e.b = shade(int'(i_blend), int'(i_b), int'(clut_b[idx]));
            e.acc = cyc + 1; e.lat = lat_mode;
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // Output-side ready pattern 1-0-0-1 when enabled
  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pc = 0;
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      if (rdy_mode) begin i_ready = pat[pc % 4]; pc++; end
      else i_ready = 1'b1;
    end
  end

  task automatic send(input pix_t p);
    bit acc;
    acc = 0;
    i_w1 = 24'(p.w1); i_w2 = 24'(p.w2); i_w3 = 24'(p.w3);
    i_u1 = 24'(p.u1); i_u2 = 24'(p.u2); i_u3 = 24'(p.u3);
    i_v1 = 24'(p.v1); i_v2 = 24'(p.v2); i_v3 = 24'(p.v3);
    i_x = 16'(p.x); i_y = 16'(p.y);
    i_r = 8'(p.r); i_g = 8'(p.g); i_b = 8'(p.b);
    i_clamp = p.clamp; i_blend = 2'(p.mode); i_key_index = 8'(p.key);
    i_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge i_clk); acc = o_ready;
      @(posedge i_clk); #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && t < 300) begin
      @(posedge i_clk); t++;
    end
    if (t >= 300) check(nm, exp_q.size(), 0);
    repeat (8) @(posedge i_clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int r, input int g, input int b);
    for (int t = 0; t < 20; t++) begin
      @(negedge i_clk);
      if (o_valid) break;
    end
    check({nm, "_valid"}, o_valid, 1);
    check({nm, "_r"}, o_r, r);
    check({nm, "_g"}, o_g, g);
    check({nm, "_b"}, o_b, b);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, seen;
    pix_t p;
    for (int a = 0; a < 65536; a++) tex_mem[a] = 8'(((a & 255) + (a >> 8)) & 127);
    for (int i = 0; i < 256; i++) begin
      clut_r[i] = 8'(i); clut_g[i] = 8'(255 - i); clut_b[i] = 8'(i * 7);
    end
    tex_mem[16'h0305] = 8'h12; clut_r[8'h12] = 8'd10;  clut_g[8'h12] = 8'd20;  clut_b[8'h12] = 8'd30;
    tex_mem[16'h040A] = 8'h21; clut_r[8'h21] = 8'd100; clut_g[8'h21] = 8'd10;  clut_b[8'h21] = 8'd255;
    tex_mem[16'h0506] = 8'h22; clut_r[8'h22] = 8'd255; clut_g[8'h22] = 8'd127; clut_b[8'h22] = 8'd50;
    tex_mem[16'h0707] = 8'h00;

    i_valid = 0; i_x = 0; i_y = 0; i_w1 = 0; i_w2 = 0; i_w3 = 0;
    i_u1 = 0; i_u2 = 0; i_u3 = 0; i_v1 = 0; i_v2 = 0; i_v3 = 0;
    i_r = 0; i_g = 0; i_b = 0; i_clamp = 0; i_blend = 0; i_key_index = 8'hFF;
    i_rst = 1'b0;
    #1 i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_tex_rd", o_tex_rd, 0);
    check("rst_o_clut_rd", o_clut_rd, 0);
    check("rst_o_tex_addr", o_tex_addr, 0);
    check("rst_o_clut_addr", o_clut_addr, 0);
    check("rst_o_x", o_x, 0);
    check("rst_o_r", o_r, 0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (2) @(posedge i_clk); #1;

    check("pin_uv_5", uv_int(256, 0, 0, 777, -555, 1280), 5);
    check("pin_uv_mix", uv_int(128, 64, 64, 2560, 5120, 7680), 22);
    check("pin_clamp_neg", fold(-1, 1), 0);
    check("pin_clamp_big", fold(300, 1), 255);
    check("pin_wrap_neg", fold(-1, 0), 255);
    check("pin_wrap_big", fold(300, 0), 44);
    check("pin_addsat", shade(0, 200, 100), 255);
    check("pin_mod_full", shade(1, 255, 255), 255);
    check("pin_mod_half", shade(1, 128, 127), 64);

    lat_mode = 1;
    send(mk(5, 3, 1, 2, 40, 50, 60, 0, 2, 255));
    for (int t = 0; t < 10; t++) begin
      @(negedge i_clk);
      if (o_tex_rd) break;
    end
    check("single_tex_addr", o_tex_addr, 16'h0305);
    expect_out("single", 10, 20, 30);
    drain("single_drain");
    lat_mode = 0;

    send(mk(10, 4, 3, 3, 200, 10, 0, 0, 0, 255));
    expect_out("addsat", 255, 20, 255);
    drain("addsat_drain");

    send(mk(6, 5, 4, 4, 255, 128, 0, 0, 1, 255));
    expect_out("modulate", 255, 64, 0);
    drain("modulate_drain");

    send(mk(-1, 2, 10, 0, 1, 2, 3, 1, 3, 255));
    send(mk(300, 2, 11, 0, 4, 5, 6, 1, 2, 255));
    repeat (2) @(posedge i_clk);
    #1;
    send(mk(-1, 2, 12, 0, 7, 8, 9, 0, 0, 255));
    @(posedge i_clk); #1;
    send(mk(300, 2, 13, 0, 250, 9, 130, 0, 1, 255));
    p = mk(0, 0, 14, -7, 90, 91, 92, 1, 1, 255);
    p.w1 = 128; p.w2 = 64; p.w3 = 64;
    p.u1 = 2560; p.u2 = 5120; p.u3 = 7680;
    p.v1 = -2560; p.v2 = -768; p.v3 = 1024;
    send(p);
    drain("addr_drain");

    c0 = out_cnt;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(mk(i * 37 - 20, i * 11, 100 + i, -i, 10 * i, 20 * i, 255 - i, 1'(i % 2), i % 4, 255));
    drain("bp_drain");
    rdy_mode = 0;
    repeat (2) @(posedge i_clk); #1;
    check("bp_count", out_cnt - c0, 8);

    for (int i = 0; i < 3; i++) send(mk(i, 9, 200 + i, 0, 5, 6, 7, 0, 2, 255));
    i_rst = 1'b1;
    #1;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_x", o_x, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    @(posedge i_clk); #1;
    lat_mode = 1;
    send(mk(8, 8, 300, 301, 1, 1, 1, 0, 3, 255));
    drain("postrst_drain");
    lat_mode = 0;

    c0 = out_cnt;
    send(mk(8, 7, 400, 0, 1, 2, 3, 0, 2, 0));
    send(mk(7, 7, 401, 0, 4, 5, 6, 0, 2, 0));
    send(mk(9, 7, 402, 0, 7, 8, 9, 0, 2, 0));
    drain("key_drain");
`ifdef TEXSHADE_CHROMA_KEY_EN
    check("key_count", out_cnt - c0, 2);
`else
    check("key_count", out_cnt - c0, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/texture_shade_stage.md
# texture_shade_stage

Parametrised texture-and-shade stage of the raster pipeline. It sits between the barycentric/colour interpolation stage and the framebuffer writer. Per pixel, it interpolates U/V from three vertex texture coordinates and fetches a palette index from external texture RAM, then a colour from external CLUT RAM. It blends that colour with the interpolated vertex colour in one of four modes. It adds a valid/ready handshake with full-pipeline stall, a selectable wrap/clamp addressing mode and configurable widths.

## Interface
- FRAC_W, 8: fractional bits of fixed-point weights and U/V; fixed-point width is 16+FRAC_W (signed).
- CH_W, 8: colour channel width.
- TEX_W_LOG2, 8: log2 texture width in texels.
- TEX_H_LOG2, 8: log2 texture height in texels.
- IDX_W, 8: palette index width.

- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid / o_ready  in/out  1  input handshake; transfer when both are high.
- i_x, i_y  in  16 signed  pixel position, passed through.
- i_w1, i_w2, i_w3  in  16+FRAC_W signed  barycentric weights.
- i_u1..i_u3, i_v1..i_v3  in  16+FRAC_W signed  vertex texture coordinates.
- i_r, i_g, i_b  in  CH_W  interpolated vertex colour.
- i_clamp  in  1  0 = repeat, 1 = clamp-to-edge.
- i_blend  in  2  0 = add-saturate, 1 = modulate, 2 = texture only, 3 = vertex only.
- i_key_index  in  IDX_W  chroma-key index (see Configuration).
- o_tex_rd, o_tex_addr  out  1, TEX_W_LOG2+TEX_H_LOG2  texture RAM read.
- i_tex_data  in  IDX_W  texture RAM data, one cycle after o_tex_rd.
- o_clut_rd, o_clut_addr  out  1, IDX_W  CLUT read.
- i_clut_r, i_clut_g, i_clut_b  in  CH_W  CLUT data, one cycle after o_clut_rd.
- o_valid / i_ready  out/in  1  output handshake.
- o_x, o_y  out  16 signed  pixel position.
- o_r, o_g, o_b  out  CH_W  shaded colour.

## Operation
- Global advance: adv = !o_valid || i_ready. o_ready = adv. When adv is low, every stage register, including all sideband, holds.
- External RAMs are synchronous. They must hold output data while their read enable is low. o_tex_rd = adv && s1_valid and o_clut_rd = adv && s2_valid.
- S0, accept: U = (w2·u1 + w3·u2 + w1·u3) >>> FRAC_W. V is formed the same way from the v coordinates. Products are full width, the sum is taken at full width, and the result is truncated toward −∞. Integer parts are U_i = U >>> FRAC_W and V_i = V >>> FRAC_W.
- S1, address:
  - Repeat mode: U_i and V_i are masked to their low TEX_W_LOG2 / TEX_H_LOG2 bits.
  - Clamp mode: negative values go to 0; values ≥ size go to size−1.
  - o_tex_addr = {V', U'}.
- S2, palette: o_clut_addr = i_tex_data.
- S3, blend, per channel, where c = vertex colour and t = CLUT colour:
  - Mode 0: min(c+t, 2^CH_W−1), computed at CH_W+1 bits.
  - Mode 1: (c·(t+1)) >> CH_W.
  - Mode 2: t.
  - Mode 3: c.
- Sideband (x, y, colour, i_clamp, i_blend, key) travels in lockstep with the valid bits.
- Reset: all stage valid bits and o_valid go to 0. o_x, o_y, o_r, o_g, o_b, o_tex_addr and o_clut_addr go to 0. o_tex_rd and o_clut_rd go to 0. Reset mid-stream discards all in-flight pixels.

## Timing
- Latency: a pixel accepted at edge k appears with o_valid at edge k+4, provided there are no stalls. Each stall cycle adds one cycle.
- Throughput: one pixel per clock while i_ready is held high.
- o_ready is combinational from o_valid and i_ready. There is no combinational path from i_valid to o_ready.
- o_valid with its data is stable while i_ready is low. Data changes only on an edge where o_valid && i_ready.
- Bubbles (i_valid low) propagate as invalid slots. They never generate RAM reads.
- Simultaneous output accept and input accept in the same cycle is legal and required for full throughput.

## Configuration
- TEXSHADE_CHROMA_KEY_EN:
  - Defined: in S3, if the palette index carried from S2 equals i_key_index (sampled with the pixel), the pixel is dropped. No o_valid is produced, and the slot becomes a bubble.
  - Undefined: i_key_index is ignored and every accepted pixel is output.

## Test plan
- Single pixel: w1=1.0, w2=w3=0, u3=5.0, v3=3.0, mode 2, clamp 0. Required: o_tex_addr=0x0305. With i_tex_data=0x12 and CLUT returning (10,20,30), the output is (10,20,30) at edge k+4.
- Add-saturate: c=(200,10,0), t=(100,10,255), mode 0 → (255,20,255). Modulate: c=255, t=255 → 255; c=128, t=127 → 64.
- Addressing: U_i=−1 and U_i=300 with clamp=1 → U'=0 and 255. With clamp=0 → U'=255 and 44.
- Backpressure: stream 8 pixels with i_ready toggling 1-0-0-1… All 8 must emerge in order, with no loss or duplication. o_x must hold while stalled, and RAM reads are never issued while adv is low.
- Reset asserted with 3 pixels in flight: o_valid=0 immediately, and no pixel emerges afterwards. The first pixel accepted after release emerges 4 cycles later.
- With TEXSHADE_CHROMA_KEY_EN, i_tex_data=i_key_index=0x00 → no output for that pixel, while neighbouring pixels are unaffected. Without the macro, the same stimulus produces output.
